// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, status bit positions and frame constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam int RX_VALID_BIT = 8;
  localparam int RX_OVR_BIT = 9;
  localparam int RX_FERR_BIT = 10;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 10;
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU read window of the UART receiver
interface uart_rx_if;
  logic uart_rd_i;
  logic [31:0] uart_data_o;
  logic rx_irq_o;
  modport master (output uart_rd_i, input uart_data_o, rx_irq_o);
  modport slave (input uart_rd_i, output uart_data_o, rx_irq_o);
endinterface

// File: rtl/uart_rx_sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers and zeroed head when empty
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_pop, do_push;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  // a pop frees the slot the simultaneous push lands in
  assign do_push = push && (!full || do_pop);
  assign head = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with receive FIFO and 32-bit status/data read word
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE = 115200,
  parameter int F_CLK = 576000,
  parameter int OVERSAMPLE = 5,
  parameter int FIFO_DEPTH = 4
) (
  input logic sys_clk_i,
  input logic sys_rst_ni,
  input logic uart_rx_i,
  uart_rx_if.slave bus
);
  localparam int DIV = F_CLK / (BAUDRATE * OVERSAMPLE);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  if (DIV < 1 || OVERSAMPLE < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      F_CLK % (BAUDRATE * OVERSAMPLE) != 0) begin : g_bad_params
    $error("uart_rx: illegal parameter combination");
  end
  logic [1:0] sync;
  logic rx_s, tick, at_samp, at_end, maj, push, full, empty, ovr;
  logic [DW-1:0] div_cnt;
  rx_state_t state, state_n;
  logic [TW-1:0] tc, tc_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [1:0] samp, samp_n;
  logic [7:0] sh, sh_n;
  logic [8:0] head;
  assign rx_s = sync[1];
  assign tick = div_cnt == DW'(DIV - 1);
  assign at_samp = tick && tc == TW'(MID + 1);
  assign at_end = tick && tc == TW'(OVERSAMPLE - 1);
  assign maj = maj3({samp, rx_s});
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni)
    if (!sys_rst_ni) begin
      sync <= 2'b11;
      div_cnt <= '0;
      state <= IDLE;
      tc <= '0;
      bitcnt <= '0;
      samp <= '0;
      sh <= '0;
    end else begin
      sync <= {sync[0], uart_rx_i};
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      state <= state_n;
      tc <= tc_n;
      bitcnt <= bitcnt_n;
      samp <= samp_n;
      sh <= sh_n;
    end
  always_comb begin
    state_n = state;
    tc_n = tick ? (at_end ? '0 : tc + 1'b1) : tc;
    bitcnt_n = bitcnt;
    sh_n = sh;
    push = 1'b0;
    samp_n = (tick && (tc == TW'(MID - 1) || tc == TW'(MID))) ? {samp[0], rx_s} : samp;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        tc_n = '0;
        bitcnt_n = '0;
      end
      START: if (at_samp && maj) state_n = IDLE;
        else if (at_end) begin
          state_n = DATA;
          bitcnt_n = '0;
        end
      DATA: begin
        if (at_samp) sh_n = {maj, sh[7:1]};
        if (at_end) begin
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == 3'(DATA_BITS - 1)) state_n = STOP;
        end
      end
      // leave STOP half a bit early so the next start edge is never missed
      STOP: if (at_samp) begin
        push = 1'b1;
        state_n = maj ? IDLE : BREAK;
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(sys_clk_i),
    .rst_n(sys_rst_ni),
    .push(push),
    .pop(bus.uart_rd_i),
    .din({~maj, sh}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni)
    if (!sys_rst_ni) ovr <= 1'b0;
    else if (push && full && !bus.uart_rd_i) ovr <= 1'b1;
    else if (bus.uart_rd_i) ovr <= 1'b0;
  always_comb begin
    bus.uart_data_o = '0;
    bus.uart_data_o[7:0] = head[7:0];
    bus.uart_data_o[RX_VALID_BIT] = ~empty;
    bus.uart_data_o[RX_OVR_BIT] = ovr;
    bus.uart_data_o[RX_FERR_BIT] = head[8];
  end
  assign bus.rx_irq_o = ~empty;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a read-response scoreboard for uart_rx
module tb_uart_rx;
  import uart_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  uart_rx_if bus ();
  uart_rx dut (.sys_clk_i(clk), .sys_rst_ni(rst_n), .uart_rx_i(rx), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    #1;
    if (bus.uart_rd_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected read: got 0x%08h expected none", bus.uart_data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("read data", bus.uart_data_o, e);
        check("read irq", {31'b0, bus.rx_irq_o}, {31'b0, e[RX_VALID_BIT]});
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    logic [FRAME_BITS-1:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic rd_expect(input logic [31:0] e);
    @(negedge clk);
    exp_q.push_back(e);
    bus.uart_rd_i = 1'b1;
    @(negedge clk);
    bus.uart_rd_i = 1'b0;
  endtask
  task automatic probe(input string name, input logic [31:0] e);
    #1;
    check(name, bus.uart_data_o, e);
    check({name, " irq"}, {31'b0, bus.rx_irq_o}, {31'b0, e[RX_VALID_BIT]});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.uart_rd_i = 1'b0;
    idle(3);
    probe("reset", 32'h0);
    rst_n = 1'b1;
    idle(3);
    send(8'h55);
    idle(2);
    probe("t1 before push", 32'h0);
    @(negedge clk);
    probe("t1 valid", 32'h155);
    rd_expect(32'h155);
    probe("t1 after read", 32'h0);
    @(negedge clk);
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(20);
    probe("t2 glitch", 32'h0);
    for (int b = 1; b <= 5; b++) send(8'(b));
    idle(5);
    rd_expect(32'h301);
    rd_expect(32'h102);
    rd_expect(32'h103);
    rd_expect(32'h104);
    rd_expect(32'h000);
    send(8'hA5, 1'b0);
    idle(100);
    probe("t4 break", 32'h5A5);
    rx = 1'b1;
    idle(10);
    send(8'h3C);
    idle(5);
    rd_expect(32'h5A5);
    rd_expect(32'h13C);
    rd_expect(32'h000);
    send(8'h7E);
    idle(5);
    probe("t5 pre reset", 32'h17E);
    fork
      send(8'hC3);
      begin
        idle(27);
        #2 rst_n = 1'b0;
        probe("t5 in reset", 32'h0);
      end
    join
    idle(3);
    rst_n = 1'b1;
    idle(5);
    send(8'hC3);
    idle(5);
    rd_expect(32'h1C3);
    rd_expect(32'h000);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    fork
      send(8'h55);
      begin
        idle(52);
        exp_q.push_back(32'h111);
        bus.uart_rd_i = 1'b1;
        @(negedge clk);
        bus.uart_rd_i = 1'b0;
      end
    join
    idle(5);
    rd_expect(32'h122);
    rd_expect(32'h133);
    rd_expect(32'h144);
    rd_expect(32'h155);
    rd_expect(32'h000);
    idle(3);
    check("queue drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
